// File: rtl/mips_16_defs.sv
// Shared loader definitions: PC width, sync byte and FSM state encodings.
// LOADER_CHECKSUM_EN adds the CHK state used by the optional trailing checksum.
`ifndef PC_WIDTH
`define PC_WIDTH 8
`endif

package mips_16_defs;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Encodings stay fixed with or without CHK so debug views are comparable.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LEN_HI  = 4'd1,
        ST_LEN_LO  = 4'd2,
        ST_WORD_HI = 4'd3,
        ST_WORD_LO = 4'd4,
`ifdef LOADER_CHECKSUM_EN
        ST_CHK     = 4'd5,
`endif
        ST_RUN     = 4'd6,
        ST_ERR     = 4'd7
    } state_t;

endpackage

// File: rtl/mips_16_prog_loader.sv
// Byte-stream program loader: A5, length (BE), N 16-bit words, optional XOR byte.
// Holds the core in reset while loading. Macro LOADER_CHECKSUM_EN enables the checksum.
// Handshake: a byte transfers on a rising edge where byte_valid and byte_ready are both 1.
module mips_16_prog_loader
    import mips_16_defs::*;
#(
    parameter int MAX_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_wr_en,
    output logic [`PC_WIDTH-1:0]  imem_wr_addr,
    output logic [15:0]           imem_wr_data,
    output logic                  core_rst,
    output logic                  loaded,
    output logic                  error,
    output logic [3:0]            dbg_state
);

    localparam int          CW    = $clog2(MAX_WORDS + 1);
    localparam logic [31:0] MAX_U = MAX_WORDS;

    state_t                 r_state;
    logic [7:0]             r_len_hi;
    logic [7:0]             r_word_hi;
    logic [CW-1:0]          r_left;
    logic [`PC_WIDTH-1:0]   r_addr;

    logic                   w_fire;
    logic                   w_sync;
    logic [15:0]            w_len;
    logic                   w_len_over;

    assign w_fire     = byte_valid & byte_ready;
    assign w_sync     = (byte_data == SYNC_BYTE);
    assign w_len      = {r_len_hi, byte_data};
    assign w_len_over = ({16'd0, w_len} > MAX_U);
    assign dbg_state  = r_state;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_xor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xor <= 8'h00;
        end else if (w_fire) begin
            if (r_state == ST_LEN_HI || r_state == ST_LEN_LO ||
                r_state == ST_WORD_HI || r_state == ST_WORD_LO) begin
                r_xor <= r_xor ^ byte_data;
            end else if (w_sync && (r_state == ST_IDLE || r_state == ST_RUN ||
                                    r_state == ST_ERR)) begin
                r_xor <= 8'h00;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_len_hi     <= 8'h00;
            r_word_hi    <= 8'h00;
            r_left       <= '0;
            r_addr       <= '0;
            byte_ready   <= 1'b0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= 16'h0000;
            core_rst     <= 1'b1;
            loaded       <= 1'b0;
            error        <= 1'b0;
        end else begin
            byte_ready <= 1'b1;
            imem_wr_en <= 1'b0;
            if (w_fire) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_sync) begin
                            r_state <= ST_LEN_HI;
                            r_addr  <= '0;
                        end
                    end
                    ST_LEN_HI: begin
                        r_len_hi <= byte_data;
                        r_state  <= ST_LEN_LO;
                    end
                    ST_LEN_LO: begin
                        r_left <= w_len[CW-1:0];
                        if (w_len_over) begin
                            r_state <= ST_ERR;
                            error   <= 1'b1;
                        end else if (w_len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            r_state  <= ST_CHK;
`else
                            r_state  <= ST_RUN;
                            core_rst <= 1'b0;
                            loaded   <= 1'b1;
`endif
                        end else begin
                            r_state <= ST_WORD_HI;
                        end
                    end
                    ST_WORD_HI: begin
                        r_word_hi <= byte_data;
                        r_state   <= ST_WORD_LO;
                    end
                    ST_WORD_LO: begin
                        imem_wr_en   <= 1'b1;
                        imem_wr_addr <= r_addr;
                        imem_wr_data <= {r_word_hi, byte_data};
                        r_addr       <= r_addr + 1'b1;
                        r_left       <= r_left - 1'b1;
                        if (r_left == CW'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                            r_state  <= ST_CHK;
`else
                            r_state  <= ST_RUN;
                            core_rst <= 1'b0;
                            loaded   <= 1'b1;
`endif
                        end else begin
                            r_state <= ST_WORD_HI;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    ST_CHK: begin
                        if (byte_data == r_xor) begin
                            r_state  <= ST_RUN;
                            core_rst <= 1'b0;
                            loaded   <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                            error   <= 1'b1;
                        end
                    end
`endif
                    // Only a fresh sync byte leaves RUN/ERR; everything else is ignored.
                    ST_RUN, ST_ERR: begin
                        if (w_sync) begin
                            r_state  <= ST_LEN_HI;
                            core_rst <= 1'b1;
                            loaded   <= 1'b0;
                            error    <= 1'b0;
                            r_addr   <= '0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_16_prog_loader.sv
// Directed bench for mips_16_prog_loader: vector table plus stall and mid-load reset sequences.
// Honours LOADER_CHECKSUM_EN when defined for the build.
`ifndef PC_WIDTH
`define PC_WIDTH 8
`endif

module tb_mips_16_prog_loader;

    localparam int PW = `PC_WIDTH;
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LEN_HI  = 4'd1;
    localparam logic [3:0] S_LEN_LO  = 4'd2;
    localparam logic [3:0] S_WORD_HI = 4'd3;
    localparam logic [3:0] S_WORD_LO = 4'd4;
    localparam logic [3:0] S_CHK     = 4'd5;
    localparam logic [3:0] S_RUN     = 4'd6;
    localparam logic [3:0] S_ERR     = 4'd7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready;
    logic          imem_wr_en;
    logic [PW-1:0] imem_wr_addr;
    logic [15:0]   imem_wr_data;
    logic          core_rst;
    logic          loaded;
    logic          error;
    logic [3:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    logic [PW+15:0] exp_q[$];
    logic [PW+15:0] mon_e;

    typedef struct {
        bit         v;
        logic [7:0] d;
        logic [8:0] exp;
    } vec_t;
    vec_t vecs[$];

    logic [8:0] w_obs;
    assign w_obs = {dbg_state, byte_ready, imem_wr_en, core_rst, loaded, error};

    always #5 clk = ~clk;

    mips_16_prog_loader #(.MAX_WORDS(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .core_rst     (core_rst),
        .loaded       (loaded),
        .error        (error),
        .dbg_state    (dbg_state)
    );

    // Scoreboard: every write pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (imem_wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write",
                         imem_wr_addr, imem_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({imem_wr_addr, imem_wr_data} !== mon_e) begin
                    errors++;
                    $display("FAIL write_data: got addr %h data %h, required addr %h data %h",
                             imem_wr_addr, imem_wr_data, mon_e[PW+15:16], mon_e[15:0]);
                end
            end
        end
    end

    function automatic logic [8:0] ob(logic [3:0] st, bit wr, bit crst, bit ld, bit er);
        return {st, 1'b1, wr, crst, ld, er};
    endfunction

    task automatic add(bit v, logic [7:0] d, logic [8:0] e);
        vec_t t;
        t.v = v;
        t.d = d;
        t.exp = e;
        vecs.push_back(t);
    endtask

    task automatic push_wr(logic [PW-1:0] a, logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic drive(bit v, logic [7:0] d);
        @(negedge clk);
        byte_valid = v;
        byte_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_obs(string name, logic [8:0] e);
        checks++;
        if (w_obs !== e) begin
            errors++;
            $display("FAIL %s: got {st,rdy,wr,crst,ld,err}=%b, required %b", name, w_obs, e);
        end
    endtask

    task automatic check_reset_outs(string name, bit rdy_zero);
        logic [PW+24:0] act;
        logic [PW+24:0] req;
        checks++;
        act = {dbg_state, byte_ready, imem_wr_en, imem_wr_addr, imem_wr_data,
               core_rst, loaded, error};
        req = {S_IDLE, ~rdy_zero, 1'b0, {PW{1'b0}}, 16'h0000, 1'b1, 1'b0, 1'b0};
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    initial begin
        // Sync filtering and a two-word load
        add(0, 8'h00, ob(S_IDLE,    0, 1, 0, 0));
        add(1, 8'h00, ob(S_IDLE,    0, 1, 0, 0));
        add(1, 8'h11, ob(S_IDLE,    0, 1, 0, 0));
        add(1, 8'hA5, ob(S_LEN_HI,  0, 1, 0, 0));
        add(1, 8'h00, ob(S_LEN_LO,  0, 1, 0, 0));
        add(1, 8'h02, ob(S_WORD_HI, 0, 1, 0, 0));
        add(1, 8'h12, ob(S_WORD_LO, 0, 1, 0, 0));
        add(0, 8'h99, ob(S_WORD_LO, 0, 1, 0, 0));
        add(1, 8'h34, ob(S_WORD_HI, 1, 1, 0, 0));
        push_wr(0, 16'h1234);
        add(1, 8'hAB, ob(S_WORD_LO, 0, 1, 0, 0));
`ifdef LOADER_CHECKSUM_EN
        add(1, 8'hCD, ob(S_CHK,     1, 1, 0, 0));
        add(1, 8'h42, ob(S_RUN,     0, 0, 1, 0));
`else
        add(1, 8'hCD, ob(S_RUN,     1, 0, 1, 0));
`endif
        push_wr(1, 16'hABCD);
        add(1, 8'h55, ob(S_RUN,     0, 0, 1, 0));
        // Restart from RUN with a one-word program
        add(1, 8'hA5, ob(S_LEN_HI,  0, 1, 0, 0));
        add(1, 8'h00, ob(S_LEN_LO,  0, 1, 0, 0));
        add(1, 8'h01, ob(S_WORD_HI, 0, 1, 0, 0));
        add(1, 8'h00, ob(S_WORD_LO, 0, 1, 0, 0));
`ifdef LOADER_CHECKSUM_EN
        add(1, 8'h07, ob(S_CHK,     1, 1, 0, 0));
        add(1, 8'h06, ob(S_RUN,     0, 0, 1, 0));
`else
        add(1, 8'h07, ob(S_RUN,     1, 0, 1, 0));
`endif
        push_wr(0, 16'h0007);
        // Zero-length program
        add(1, 8'hA5, ob(S_LEN_HI,  0, 1, 0, 0));
        add(1, 8'h00, ob(S_LEN_LO,  0, 1, 0, 0));
`ifdef LOADER_CHECKSUM_EN
        add(1, 8'h00, ob(S_CHK,     0, 1, 0, 0));
        add(1, 8'h00, ob(S_RUN,     0, 0, 1, 0));
`else
        add(1, 8'h00, ob(S_RUN,     0, 0, 1, 0));
`endif
        // Overlong count 257 aborts; ERR ignores stray bytes
        add(1, 8'hA5, ob(S_LEN_HI,  0, 1, 0, 0));
        add(1, 8'h01, ob(S_LEN_LO,  0, 1, 0, 0));
        add(1, 8'h01, ob(S_ERR,     0, 1, 0, 1));
        add(1, 8'h33, ob(S_ERR,     0, 1, 0, 1));
`ifdef LOADER_CHECKSUM_EN
        add(1, 8'hA5, ob(S_LEN_HI,  0, 1, 0, 0));
        add(1, 8'h00, ob(S_LEN_LO,  0, 1, 0, 0));
        add(1, 8'h01, ob(S_WORD_HI, 0, 1, 0, 0));
        add(1, 8'h12, ob(S_WORD_LO, 0, 1, 0, 0));
        add(1, 8'h34, ob(S_CHK,     1, 1, 0, 0));
        push_wr(0, 16'h1234);
        add(1, 8'hFF, ob(S_ERR,     0, 1, 0, 1));
`endif
        // Count of exactly MAX_WORDS is accepted
        add(1, 8'hA5, ob(S_LEN_HI,  0, 1, 0, 0));
        add(1, 8'h01, ob(S_LEN_LO,  0, 1, 0, 0));
        add(1, 8'h00, ob(S_WORD_HI, 0, 1, 0, 0));

        #1 rst = 1'b1;
        #3 check_reset_outs("reset_state", 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1 check_reset_outs("ready_low_after_release", 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].d);
            check_obs($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Stall with 5-cycle gaps mid-word
        drive(1, 8'hBE);
        check_obs("stall_hi", ob(S_WORD_LO, 0, 1, 0, 0));
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'h5A);
            check_obs($sformatf("stall_gap%0d", i), ob(S_WORD_LO, 0, 1, 0, 0));
        end
        push_wr(0, 16'hBEEF);
        drive(1, 8'hEF);
        check_obs("stall_lo", ob(S_WORD_HI, 1, 1, 0, 0));
        drive(1, 8'h12);
        repeat (5) drive(0, 8'hC3);
        push_wr(1, 16'h1234);
        drive(1, 8'h34);
        check_obs("stall_word2", ob(S_WORD_HI, 1, 1, 0, 0));

        // Asynchronous reset between WORD_HI and WORD_LO
        drive(1, 8'h56);
        check_obs("midload_hi", ob(S_WORD_LO, 0, 1, 0, 0));
        @(negedge clk);
        byte_data = 8'h78;
        #2 rst = 1'b1;
        #1 check_reset_outs("async_reset", 1'b1);
        @(posedge clk);
        #1 check_reset_outs("reset_held", 1'b1);
        @(negedge clk);
        rst = 1'b0;
        byte_valid = 1'b0;
        drive(0, 8'h00);
        check_reset_outs("after_reset_ready", 1'b0);
        drive(1, 8'h56);
        check_obs("idle_discard", ob(S_IDLE, 0, 1, 0, 0));
        drive(0, 8'h00);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: got %0d writes outstanding, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
